clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock divider, the parametrised successor to the fixed divider used for slow housekeeping clocks. Each channel produces a divided waveform with runtime-selectable period and high time, plus a one-cycle period-start strobe. Typical consumers are EPD source/gate timing generators and LED/PWM-style outputs, all in the system clock domain. Settings change glitch-free at period boundaries, and a common sync input phase-aligns all channels.

## Interface
- `CHANNELS`, 2: number of independent divider channels (≥1).
- `WIDTH`, 16: counter, period and high-time width per channel.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_i` in CHANNELS: per-channel enable.
- `div_i` in CHANNELS*WIDTH: period in clk cycles. Channel c uses bits `[c*WIDTH +: WIDTH]`.
- `high_i` in CHANNELS*WIDTH: high time in clk cycles. Packed the same way as `div_i`.
- `sync_i` in 1: restarts every enabled channel simultaneously.
- `o` out CHANNELS: divided output, registered.
- `tick_o` out CHANNELS: one-cycle pulse on the first cycle of each period, registered.

## Operation
Per-channel registers are `cnt`, `act_div`, `act_high`, `en_q`, `o` and `tick_o`.
- Reset: `cnt`=0, `act_div`=2, `act_high`=0, `en_q`=0, `o`=0, `tick_o`=0.
- Effective period is `max(div_i, 2)`. Values 0 and 1 are clamped to 2.
- At each edge, exactly one of the following applies, evaluated in priority order:
  - **Disable** (`en_i`=0): `cnt`←0, `o`←0, `tick_o`←0, `en_q`←0.
  - **Load**: applies when `en_i`=1 and any of these holds: `en_q`=0 (start), `sync_i`=1, or `cnt`==`act_div`−1 (wrap). Actions: `cnt`←0, `act_div`←clamp(`div_i`), `act_high`←`high_i`, `o`←(`high_i`≠0), `tick_o`←1, `en_q`←1.
  - **Count**: all other cases. `cnt`←`cnt`+1, `o`←(`cnt`+1 < `act_high`), `tick_o`←0.
- Consequences of these rules:
  - `o` is high for `min(act_high, act_div)` cycles, then low for the rest of the period.
  - `high`=0 gives constant 0 with ticks still running. `high`≥`div` gives constant 1.
- `div_i` and `high_i` are sampled only on load. A change mid-period takes effect at the next period start, never truncating the current period.
- Simultaneous sync and wrap produce one load, not two.
- Channels are fully independent apart from `sync_i`.
- Comparisons are unsigned at WIDTH bits. `cnt`+1 cannot overflow because `cnt` < `act_div` ≤ 2^WIDTH−1.

## Timing
- Latency from `en_i` rising (sampled at edge k) to `o`/`tick_o` valid is edge k. The first period starts in the cycle after edge k.
- Period is exactly `act_div` cycles, for both odd and even values. Duty cycle is `act_high`/`act_div`, with no half-cycle resolution.
- `tick_o` coincides with the first high cycle of `o` whenever `act_high`>0.
- After `sync_i` is sampled at edge k, all enabled channels show `tick_o`=1 in the same cycle after edge k.
- Disable takes effect at the next edge: `o`=0 one cycle after `en_i` is sampled low.
- Reset mid-operation:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After `rst_n` deasserts, a channel whose `en_i` is held 1 starts on the first edge, because `en_q`=0.
- Outputs are glitch-free because they are registered. `o` must not be used directly as a clock without a BUFG/clock-enable review.

## Structure
- One natural sub-module, `clk_div_chan`, holds a single channel: parameter WIDTH, and ports `clk`, `rst_n`, `en_i`, `sync_i`, `div_i`, `high_i`, `o`, `tick_o`.
- The top level instantiates `clk_div_chan` CHANNELS times in a generate loop and slices the packed buses.
- No shared package is needed. `MIN_DIV`=2 is a localparam in `clk_div_chan`.

## Test plan
- **Even divide:** ch0 `div`=4, `high`=2, `en`↑ → `o`=1,1,0,0 repeating; `tick_o` every 4th cycle, aligned to the first 1.
- **Odd divide:** `div`=5, `high`=2 → `o`=1,1,0,0,0 with period 5.
- **Mid-period update:** `div` changes 4→6 when `cnt`=1 → the current period still lasts 4 cycles, the next lasts 6, with no short pulse.
- **Clamps and saturation:**
  - `div`=0 and `div`=1 → period 2.
  - `high`=0 → `o` constantly 0 while ticks continue every period.
  - `high`=7, `div`=4 → `o` constantly 1.
- **Sync and disable:**
  - ch0 `div`=3, ch1 `div`=4 running out of phase; pulse `sync_i` → both `tick_o` high in the same cycle one edge later.
  - Drop ch1 `en_i` → ch1 `o`=0 at the next cycle while ch0 is unaffected.
- **Reset mid-run:** assert `rst_n`=0 while `o`=1 → `o` and `tick_o` go to 0 without a clock edge. Release with `en_i` held 1 → `tick_o`=1 after the first edge, and the full period is restored.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// Shared defaults for the multi-channel clock divider.
// Channel-level constants such as the minimum period stay local to clk_div_chan.
package clk_div_multi_pkg;

    localparam int DEF_CHANNELS = 2;
    localparam int DEF_WIDTH    = 16;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: registered divided output plus a period-start strobe.
// Period and high time are captured only at period start, so updates never truncate a period.
module clk_div_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic [WIDTH-1:0] high_i,
    output logic             o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_div;
    logic [WIDTH-1:0] act_high;
    logic             en_q;

    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] div_clamped;
    logic             load;

    // cnt < act_div <= 2^WIDTH-1, so the increment never wraps.
    assign cnt_inc     = cnt + 1'b1;
    assign div_clamped = (div_i < MIN_DIV) ? MIN_DIV : div_i;
    // Start, sync and wrap all collapse into a single load.
    assign load        = !en_q || sync_i || (cnt == act_div - 1'b1);

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            act_div  <= MIN_DIV;
            act_high <= '0;
            en_q     <= 1'b0;
            o        <= 1'b0;
            tick_o   <= 1'b0;
        end else if (!en_i) begin
            cnt    <= '0;
            o      <= 1'b0;
            tick_o <= 1'b0;
            en_q   <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            act_div  <= div_clamped;
            act_high <= high_i;
            o        <= (high_i != '0);
            tick_o   <= 1'b1;
            en_q     <= 1'b1;
        end else begin
            cnt    <= cnt_inc;
            o      <= (cnt_inc < act_high);
            tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; channels share only clk, reset and sync.
// Packed div/high buses are sliced per channel as [c*WIDTH +: WIDTH].
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS*WIDTH-1:0] div_i,
    input  logic [CHANNELS*WIDTH-1:0] high_i,
    input  logic                      sync_i,
    output logic [CHANNELS-1:0]       o,
    output logic [CHANNELS-1:0]       tick_o
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clk_div_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en_i[c]),
            .sync_i (sync_i),
            .div_i  (div_i[c*WIDTH +: WIDTH]),
            .high_i (high_i[c*WIDTH +: WIDTH]),
            .o      (o[c]),
            .tick_o (tick_o[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed, table-driven bench for clk_div_multi with two 16-bit channels.
// Expected waveforms are hand-computed; inputs change 1 time unit after each rising edge.
module tb_clk_div_multi;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 16;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] d0;
        logic [15:0] h0;
        logic [15:0] d1;
        logic [15:0] h1;
        logic        sync;
        logic [1:0]  exp_o;
        logic [1:0]  exp_tick;
    } vec_t;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS-1:0]       en_i;
    logic [CHANNELS*WIDTH-1:0] div_i;
    logic [CHANNELS*WIDTH-1:0] high_i;
    logic                      sync_i;
    logic [CHANNELS-1:0]       o;
    logic [CHANNELS-1:0]       tick_o;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    clk_div_multi #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .div_i  (div_i),
        .high_i (high_i),
        .sync_i (sync_i),
        .o      (o),
        .tick_o (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, compare outputs 1 unit after the edge.
    task automatic apply(input string name, input logic [1:0] en,
                         input logic [15:0] d0, input logic [15:0] h0,
                         input logic [15:0] d1, input logic [15:0] h1,
                         input logic sync, input logic [1:0] exp_o, input logic [1:0] exp_tick);
        en_i   = en;
        div_i  = {d1, d0};
        high_i = {h1, h0};
        sync_i = sync;
        @(posedge clk);
        #1;
        check({name, "_o"}, o, exp_o);
        check({name, "_tick"}, tick_o, exp_tick);
    endtask

    task automatic v(input logic [1:0] en, input logic [15:0] d0, input logic [15:0] h0,
                     input logic [15:0] d1, input logic [15:0] h1, input logic sync,
                     input logic [1:0] exp_o, input logic [1:0] exp_tick);
        vec_t r;
        r.en = en; r.d0 = d0; r.h0 = h0; r.d1 = d1; r.h1 = h1;
        r.sync = sync; r.exp_o = exp_o; r.exp_tick = exp_tick;
        vecs.push_back(r);
    endtask

    initial begin
        // Even divide: ch0 div 4, high 2 -> 1,1,0,0 with tick on the first 1.
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 4, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 4, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 4, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 4, 2, 0, 0, 0, 2'b00, 2'b00);
        // Odd divide: div 5, high 2 loaded at the wrap -> 1,1,0,0,0.
        v(2'b01, 5, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 5, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 5, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 5, 2, 0, 0, 0, 2'b00, 2'b00);
        // Mid-period update: div 4 loaded, changed to 6 at cnt=1; current period keeps 4.
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 4, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 6, 2, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 6, 2, 0, 0, 0, 2'b01, 2'b01);
        // div 0 clamps to 2 on ch0; ch1 div 3, high 0 stays low while ticking.
        v(2'b00, 0, 1, 3, 0, 0, 2'b00, 2'b00);
        v(2'b11, 0, 1, 3, 0, 0, 2'b01, 2'b11);
        v(2'b11, 0, 1, 3, 0, 0, 2'b00, 2'b00);
        v(2'b11, 0, 1, 3, 0, 0, 2'b01, 2'b01);
        v(2'b11, 0, 1, 3, 0, 0, 2'b00, 2'b10);
        v(2'b11, 0, 1, 3, 0, 0, 2'b01, 2'b01);
        v(2'b11, 0, 1, 3, 0, 0, 2'b00, 2'b00);
        // div 1 also clamps to 2.
        v(2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 1, 1, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 1, 1, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        // high 7 > div 4: output saturates high, ticks every 4.
        v(2'b00, 4, 7, 0, 0, 0, 2'b00, 2'b00);
        v(2'b01, 4, 7, 0, 0, 0, 2'b01, 2'b01);
        v(2'b01, 4, 7, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 4, 7, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 4, 7, 0, 0, 0, 2'b01, 2'b00);
        v(2'b01, 4, 7, 0, 0, 0, 2'b01, 2'b01);

        rst_n  = 1'b0;
        en_i   = '0;
        div_i  = '0;
        high_i = '0;
        sync_i = 1'b0;
        #12;
        check("reset_o", o, 2'b00);
        check("reset_tick", tick_o, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i].en, vecs[i].d0, vecs[i].h0,
                  vecs[i].d1, vecs[i].h1, vecs[i].sync, vecs[i].exp_o, vecs[i].exp_tick);
        end

        // Sync: ch0 div 3 and ch1 div 4 started one cycle apart, then realigned.
        apply("sync_s1",  2'b00, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("sync_s2",  2'b01, 3, 1, 4, 2, 0, 2'b01, 2'b01);
        apply("sync_s3",  2'b11, 3, 1, 4, 2, 0, 2'b10, 2'b10);
        apply("sync_s4",  2'b11, 3, 1, 4, 2, 0, 2'b10, 2'b00);
        apply("sync_s5",  2'b11, 3, 1, 4, 2, 1, 2'b11, 2'b11);
        apply("sync_s6",  2'b11, 3, 1, 4, 2, 0, 2'b10, 2'b00);
        apply("sync_s7",  2'b11, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        // Sync on ch0's wrap edge gives a single load and a full following period.
        apply("sync_s8",  2'b11, 3, 1, 4, 2, 1, 2'b11, 2'b11);
        apply("sync_s9",  2'b11, 3, 1, 4, 2, 0, 2'b10, 2'b00);
        apply("sync_s10", 2'b11, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("sync_s11", 2'b11, 3, 1, 4, 2, 0, 2'b01, 2'b01);
        // Drop ch1 on the edge where it would have wrapped; ch0 keeps its cadence.
        apply("dis_s1",   2'b01, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("dis_s2",   2'b01, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("dis_s3",   2'b01, 3, 1, 4, 2, 0, 2'b01, 2'b01);

        // Reset while o and tick are high: outputs clear with no clock edge.
        rst_n = 1'b0;
        #1;
        check("rst_async_o", o, 2'b00);
        check("rst_async_tick", tick_o, 2'b00);
        @(posedge clk);
        #1;
        check("rst_hold_o", o, 2'b00);
        check("rst_hold_tick", tick_o, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        apply("rst_r1", 2'b01, 3, 1, 4, 2, 0, 2'b01, 2'b01);
        apply("rst_r2", 2'b01, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("rst_r3", 2'b01, 3, 1, 4, 2, 0, 2'b00, 2'b00);
        apply("rst_r4", 2'b01, 3, 1, 4, 2, 0, 2'b01, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
